// File: rtl/pc_fetch_control_pkg.sv
// Shared fetch-side definitions for the 16-bit pipelined core.
//   PC_WIDTH_DEF  : default PC / target width
//   PC_INCR       : sequential fetch step in bytes
//   FLUSH_CNT_W   : width of the redirect flush down-counter
//   fetch_state_t : RUN / FLUSH / HALTED sequencer states
package pc_fetch_control_pkg;

    localparam int PC_WIDTH_DEF = 16;
    localparam int PC_INCR      = 2;
    localparam int FLUSH_CNT_W  = 3;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_FLUSH  = 2'd1,
        ST_HALTED = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/pc_fetch_control_flush_counter.sv
// Loadable 3-bit down-counter that times the post-redirect flush window.
//   i_clk      : clock
//   i_rst      : synchronous reset, clears the count
//   i_load     : load i_load_val (takes priority over decrement)
//   i_load_val : reload value
//   o_count    : current count
//   o_nonzero  : count != 0
module pc_fetch_control_flush_counter
    import pc_fetch_control_pkg::*;
(
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_load,
    input  logic [FLUSH_CNT_W-1:0] i_load_val,
    output logic [FLUSH_CNT_W-1:0] o_count,
    output logic                   o_nonzero
);

    logic [FLUSH_CNT_W-1:0] r_count;
    logic                   w_nonzero;

    assign w_nonzero = (r_count != '0);

    // Reload replaces any remaining count rather than adding to it; the
    // countdown keeps running regardless of stall.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (w_nonzero) begin
            r_count <= r_count - 1'b1;
        end
    end

    assign o_count   = r_count;
    assign o_nonzero = w_nonzero;

endmodule

// File: rtl/pc_fetch_control_sreg.sv
// Generic register cell with synchronous active-high reset and load enable.
//   i_clk : clock
//   i_rst : synchronous reset, loads RST_VAL
//   i_en  : load enable
//   i_d   : next value
//   o_q   : registered value
module pc_fetch_control_sreg #(
    parameter int             W       = 1,
    parameter logic [W-1:0]   RST_VAL = '0
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_en,
    input  logic [W-1:0] i_d,
    output logic [W-1:0] o_q
);

    logic [W-1:0] r_q;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_q <= RST_VAL;
        end else if (i_en) begin
            r_q <= i_d;
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/pc_fetch_control.sv
// Fetch-side program-counter sequencer. Owns the architectural PC, the
// sticky halt and misalign flags, and the multi-cycle flush after a redirect.
//   i_clk, i_rst         : clock, synchronous active-high reset
//   i_branch_taken       : resolved branch decision
//   i_branch_target      : branch destination
//   i_jump, i_jump_target: unconditional jump and destination (wins over branch)
//   i_stall              : hold sequential advance
//   i_imem_ready         : instruction word at o_pc available this cycle
//   i_halt               : HALT decoded from the word at o_pc
//   o_pc, o_pc_plus2     : fetch address and its sequential successor
//   o_fetch_valid        : fetched word valid for decode
//   o_flush              : squash younger stages
//   o_halted, o_misalign : sticky status flags
module pc_fetch_control
    import pc_fetch_control_pkg::*;
#(
    parameter int               WIDTH        = PC_WIDTH_DEF,
    parameter logic [WIDTH-1:0] RESET_PC     = '0,
    parameter int               FLUSH_CYCLES = 2
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_branch_taken,
    input  logic [WIDTH-1:0] i_branch_target,
    input  logic             i_jump,
    input  logic [WIDTH-1:0] i_jump_target,
    input  logic             i_stall,
    input  logic             i_imem_ready,
    input  logic             i_halt,
    output logic [WIDTH-1:0] o_pc,
    output logic [WIDTH-1:0] o_pc_plus2,
    output logic             o_fetch_valid,
    output logic             o_flush,
    output logic             o_halted,
    output logic             o_misalign
);

    fetch_state_t r_state;
    fetch_state_t w_state_next;

    logic [WIDTH-1:0]       w_pc;
    logic [WIDTH-1:0]       w_pc_next;
    logic [WIDTH-1:0]       w_pc_plus2;
    logic [WIDTH-1:0]       w_target;
    logic                   w_in_halted;
    logic                   w_redirect;
    logic                   w_halt_take;
    logic                   w_hold;
    logic                   w_flush;
    logic                   w_cnt_nz;
    logic [FLUSH_CNT_W-1:0] w_cnt;
    logic                   w_halted;
    logic                   w_misalign;

    assign w_in_halted = (r_state == ST_HALTED);
    assign w_pc_plus2  = w_pc + WIDTH'(PC_INCR);
    assign w_target    = i_jump ? i_jump_target : i_branch_target;

    // Once halted, every control input is ignored until reset.
    assign w_redirect  = (i_jump | i_branch_taken) & ~w_in_halted;
    assign w_flush     = w_cnt_nz & ~w_in_halted;
    // A HALT seen while flushing came from a wrong-path word.
    assign w_halt_take = i_halt & ~w_flush & i_imem_ready & ~w_in_halted & ~w_redirect;
    assign w_hold      = i_stall | ~i_imem_ready;

    always_comb begin
        w_pc_next = w_pc;
        if (w_redirect) begin
            w_pc_next = {w_target[WIDTH-1:1], 1'b0};
        end else if (w_halt_take || w_hold || w_in_halted) begin
            w_pc_next = w_pc;
        end else begin
            w_pc_next = w_pc_plus2;
        end
    end

    pc_fetch_control_sreg #(.W(WIDTH), .RST_VAL(RESET_PC)) u_pc_reg (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .i_en  (1'b1),
        .i_d   (w_pc_next),
        .o_q   (w_pc)
    );

    pc_fetch_control_sreg #(.W(1), .RST_VAL(1'b0)) u_halted_reg (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .i_en  (w_halt_take),
        .i_d   (1'b1),
        .o_q   (w_halted)
    );

    pc_fetch_control_sreg #(.W(1), .RST_VAL(1'b0)) u_misalign_reg (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .i_en  (w_redirect & w_target[0]),
        .i_d   (1'b1),
        .o_q   (w_misalign)
    );

    pc_fetch_control_flush_counter u_flush_cnt (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_load     (w_redirect),
        .i_load_val (FLUSH_CNT_W'(FLUSH_CYCLES)),
        .o_count    (w_cnt),
        .o_nonzero  (w_cnt_nz)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= ST_RUN;
        end else begin
            r_state <= w_state_next;
        end
    end

    // FLUSH mirrors "counter will be nonzero next cycle": a count of 1
    // decrements to 0, so the state returns to RUN on that edge.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_HALTED: w_state_next = ST_HALTED;
            default: begin
                if (w_redirect) begin
                    w_state_next = ST_FLUSH;
                end else if (w_halt_take) begin
                    w_state_next = ST_HALTED;
                end else if (w_cnt > FLUSH_CNT_W'(1)) begin
                    w_state_next = ST_FLUSH;
                end else begin
                    w_state_next = ST_RUN;
                end
            end
        endcase
    end

    assign o_pc          = w_pc;
    assign o_pc_plus2    = w_pc_plus2;
    assign o_fetch_valid = i_imem_ready & ~i_stall & ~w_in_halted;
    assign o_flush       = w_flush;
    assign o_halted      = w_halted;
    assign o_misalign    = w_misalign;

endmodule

// File: tb/tb_pc_fetch_control.sv
// Directed bench for pc_fetch_control: sequential fetch, redirects, flush
// window, misalign, halt, stall, wrap and reset priority.
module tb_pc_fetch_control;

    logic        clk = 1'b0;
    logic        rst;
    logic        branch_taken;
    logic [15:0] branch_target;
    logic        jump;
    logic [15:0] jump_target;
    logic        stall;
    logic        imem_ready;
    logic        halt;
    logic [15:0] pc;
    logic [15:0] pc_plus2;
    logic        fetch_valid;
    logic        flush;
    logic        halted;
    logic        misalign;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    pc_fetch_control #(.WIDTH(16), .RESET_PC(16'h0000), .FLUSH_CYCLES(2)) dut (
        .i_clk          (clk),
        .i_rst          (rst),
        .i_branch_taken (branch_taken),
        .i_branch_target(branch_target),
        .i_jump         (jump),
        .i_jump_target  (jump_target),
        .i_stall        (stall),
        .i_imem_ready   (imem_ready),
        .i_halt         (halt),
        .o_pc           (pc),
        .o_pc_plus2     (pc_plus2),
        .o_fetch_valid  (fetch_valid),
        .o_flush        (flush),
        .o_halted       (halted),
        .o_misalign     (misalign)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; branch_taken = 1'b0; branch_target = '0;
        jump = 1'b1; jump_target = 16'h0400;  // reset must beat a same-cycle jump
        stall = 1'b0; imem_ready = 1'b1; halt = 1'b1;
        step();
        jump = 1'b0; halt = 1'b0; rst = 1'b0;
        #1;
        chk("rst_pc", pc, 16'h0000);
        chk("rst_flush", flush, 1'b0);
        chk("rst_halted", halted, 1'b0);
        chk("rst_misalign", misalign, 1'b0);
        chk("rst_fv", fetch_valid, 1'b1);
        chk("rst_plus2", pc_plus2, 16'h0002);

        // Sequential fetch
        step(); chk("seq_pc1", pc, 16'h0002); chk("seq_fv1", fetch_valid, 1'b1);
        step(); chk("seq_pc2", pc, 16'h0004); chk("seq_fl2", flush, 1'b0);
        step(); chk("seq_pc3", pc, 16'h0006); chk("seq_fv3", fetch_valid, 1'b1);

        // Branch redirect at 0x0006
        branch_taken = 1'b1; branch_target = 16'h0040;
        step(); branch_taken = 1'b0; #1;
        chk("br_pc", pc, 16'h0040); chk("br_fl1", flush, 1'b1);
        step(); chk("br_pc2", pc, 16'h0042); chk("br_fl2", flush, 1'b1);
        step(); chk("br_pc3", pc, 16'h0044); chk("br_fl3", flush, 1'b0);

        // Jump wins over branch
        jump = 1'b1; jump_target = 16'h1000; branch_taken = 1'b1; branch_target = 16'h2000;
        step(); jump = 1'b0; branch_taken = 1'b0; #1;
        chk("jb_pc", pc, 16'h1000); chk("jb_fl", flush, 1'b1);
        chk("jb_mis", misalign, 1'b0);
        step(); step(); chk("jb_pc2", pc, 16'h1004); chk("jb_fl2", flush, 1'b0);

        // Misaligned target, then re-redirect on the last flush cycle
        jump = 1'b1; jump_target = 16'h0033;
        step(); jump = 1'b0; #1;
        chk("mis_pc", pc, 16'h0032); chk("mis_flag", misalign, 1'b1);
        step(); chk("mis_pc2", pc, 16'h0034); chk("mis_fl2", flush, 1'b1);
        branch_taken = 1'b1; branch_target = 16'h0050;
        step(); branch_taken = 1'b0; #1;
        chk("rr_pc", pc, 16'h0050); chk("rr_fl1", flush, 1'b1);
        step(); chk("rr_fl2", flush, 1'b1); chk("rr_pc2", pc, 16'h0052);
        step(); chk("rr_fl3", flush, 1'b0); chk("rr_mis", misalign, 1'b1);

        // Halt during flush is ignored
        branch_taken = 1'b1; branch_target = 16'h000C;
        step(); branch_taken = 1'b0; halt = 1'b1; #1;
        chk("hf_pc", pc, 16'h000C);
        step(); chk("hf_halted1", halted, 1'b0); chk("hf_pc1", pc, 16'h000E);
        step(); chk("hf_halted2", halted, 1'b0); chk("hf_pc2", pc, 16'h0010);
        chk("hf_fl", flush, 1'b0);

        // Real halt at 0x0010
        step();
        chk("h_halted", halted, 1'b1); chk("h_pc", pc, 16'h0010);
        chk("h_fv", fetch_valid, 1'b0); chk("h_fl", flush, 1'b0);
        halt = 1'b0; branch_taken = 1'b1; branch_target = 16'h0200;
        step(); branch_taken = 1'b0; #1;
        chk("h_br_pc", pc, 16'h0010); chk("h_br_fl", flush, 1'b0);
        chk("h_br_halted", halted, 1'b1); chk("h_mis", misalign, 1'b1);
        rst = 1'b1;
        step(); rst = 1'b0; #1;
        chk("hr_pc", pc, 16'h0000); chk("hr_halted", halted, 1'b0);
        chk("hr_mis", misalign, 1'b0); chk("hr_fv", fetch_valid, 1'b1);

        // Stall for 3 cycles
        stall = 1'b1;
        step(); chk("st_pc1", pc, 16'h0000); chk("st_fv", fetch_valid, 1'b0);
        step(); chk("st_pc2", pc, 16'h0000);
        step(); chk("st_pc3", pc, 16'h0000);
        stall = 1'b0;
        step(); chk("st_rel", pc, 16'h0002);

        // Wrap 0xFFFE -> 0x0000
        jump = 1'b1; jump_target = 16'hFFFE;
        step(); jump = 1'b0; #1;
        chk("wr_pc", pc, 16'hFFFE); chk("wr_plus2", pc_plus2, 16'h0000);
        step(); chk("wr_pc2", pc, 16'h0000);
        step(); chk("wr_pc3", pc, 16'h0002);

        // imem not ready holds; redirect still lands
        imem_ready = 1'b0;
        step(); chk("im_pc", pc, 16'h0002); chk("im_fv", fetch_valid, 1'b0);
        branch_taken = 1'b1; branch_target = 16'h0100; stall = 1'b1;
        step(); branch_taken = 1'b0; stall = 1'b0; imem_ready = 1'b1; #1;
        chk("im_br_pc", pc, 16'h0100); chk("im_br_fl", flush, 1'b1);
        step(); chk("im_adv", pc, 16'h0102);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/pc_fetch_control.md
# pc_fetch_control

Fetch-side program-counter sequencer for the 16-bit pipelined core. It consumes the taken/not-taken decision from the branch decision logic, the jump resolution from decode, and stall and halt controls. It produces the fetch address and a multi-cycle flush for younger pipeline stages. It owns the only architectural PC register and the sticky halt state.

## Interface
- `WIDTH`, 16, PC / target width in bits
- `RESET_PC`, 16'h0000, PC value loaded on reset
- `FLUSH_CYCLES`, 2, cycles `flush` stays high after a redirect (1..7)

- `clk`  in  1  core clock; all state updates on rising edge
- `rst`  in  1  reset; one clock, synchronous, active-high
- `branch_taken`  in  1  resolved branch decision from branch decision logic (already gated by branch enable)
- `branch_target`  in  WIDTH  branch destination
- `jump`  in  1  unconditional jump resolved
- `jump_target`  in  WIDTH  jump destination
- `stall`  in  1  hazard stall; hold sequential advance
- `imem_ready`  in  1  instruction word for current `pc` is available this cycle
- `halt`  in  1  HALT decoded from the instruction fetched at `pc`
- `pc`  out  WIDTH  current fetch address
- `pc_plus2`  out  WIDTH  `pc + 2`, modulo 2^WIDTH
- `fetch_valid`  out  1  fetched word this cycle is valid for decode
- `flush`  out  1  squash younger stages
- `halted`  out  1  sticky; core stopped
- `misalign`  out  1  sticky; a redirect target had bit 0 set

## Operation
- Reset values: `pc`=RESET_PC, `flush`=0, flush counter=0, `halted`=0, `misalign`=0, state RUN.
- States:
  - RUN: normal operation.
  - FLUSH: flush counter nonzero.
  - HALTED: terminal until `rst`.
- `flush` = (counter != 0), decoded from the registered counter.
- Per-cycle priority in RUN/FLUSH, highest first:
  1. Redirect. Condition: `jump | branch_taken`. `jump_target` wins if both are high. Next `pc` = target with bit 0 forced to 0. If target bit 0 = 1, set `misalign`. Counter loads FLUSH_CYCLES; state goes to FLUSH.
  2. Halt. Condition: `halt & ~flush & imem_ready`. State goes to HALTED and `halted` is set; `pc` holds. Halt from a wrong-path word (`flush`=1) is ignored.
  3. Hold. Condition: `stall | ~imem_ready`. `pc` holds.
  4. Advance. Next `pc` = `pc_plus2`, wrapping 0xFFFE -> 0x0000.
- Counter behaviour:
  - Decrements by 1 each cycle it is nonzero and no redirect occurs. Stall does not freeze it.
  - At 0, state returns to RUN.
  - A redirect while in FLUSH reloads the counter to FLUSH_CYCLES; no accumulation.
- `fetch_valid` = `imem_ready & ~stall & ~halted`. It is combinational from inputs and state. It is independent of `flush`; downstream squashes using `flush`.
- HALTED:
  - Redirect, stall, and halt inputs are ignored.
  - `pc` is frozen; `flush` = 0.
  - `fetch_valid` = 0.
- `rst` has priority over everything, including a same-cycle redirect or halt.

## Timing
- Redirect sampled at edge t:
  - `pc` = target during cycle t+1.
  - `flush` is high cycles t+1 .. t+FLUSH_CYCLES.
- Halt sampled at edge t: `halted`=1 from cycle t+1; `pc` unchanged.
- Sequential advance: one PC step per cycle with `imem_ready=1, stall=0`. Zero bubbles.
- `pc`, `halted`, `misalign`, and the counter are registered. `pc_plus2`, `flush`, and `fetch_valid` are combinational from registers and inputs.
- A redirect concurrent with `stall=1` or `imem_ready=0` still takes effect at the next edge.

## Structure
- Shared core package holds:
  - `WIDTH` default
  - PC increment constant (2)
  - state encoding: RUN, FLUSH, HALTED
- One natural sub-module: `flush_counter`, a loadable down-counter (3 bits) with a nonzero flag. Everything else stays in `pc_fetch_control`.
- Reuses the codebase's synchronous-reset register cell for `pc` and the sticky bits.

## Test plan
- Reset, then 4 cycles with `imem_ready`=1, `stall`=0: `pc` sequence is 0x0000, 0x0002, 0x0004, 0x0006; `fetch_valid`=1 throughout; `flush`=0.
- Branch redirect: `branch_taken`=1, `branch_target`=0x0040 at pc 0x0006.
  - Next cycle `pc`=0x0040.
  - `flush` is high exactly 2 cycles.
  - Then `pc` is 0x0042, 0x0044.
- Jump and branch in the same cycle: `jump_target`=0x1000, `branch_target`=0x2000 → `pc`=0x1000.
- Misaligned target and re-redirect:
  - `jump_target`=0x0033 → `pc`=0x0032 and `misalign` stays 1.
  - A second redirect during `flush` reloads the counter: `flush` is high 2 cycles after the second redirect.
- Halt cases:
  - `halt`=1 while `flush`=1 is ignored.
  - `halt`=1 with `flush`=0 at pc 0x0010 → `halted`=1, `pc` stays 0x0010, `fetch_valid`=0.
  - A later `branch_taken` is ignored.
  - `rst` restores 0x0000 and clears `halted`.
- Stall and wrap:
  - `stall`=1 for 3 cycles holds `pc`.
  - `pc`=0xFFFE advance → 0x0000.
  - `imem_ready`=0 holds `pc`; a redirect during `imem_ready`=0 still takes effect.
